// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache straddling IF0/IF1: synchronous tag/data read
// in IF0, hit/miss decision and instruction return in IF1, line refill over a valid/ready port.
module icache_dm #(
  parameter int WORD       = 32,
  parameter int LINE_WORDS = 4,
  parameter int INDEX_BITS = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall,
  input  logic                       flush,
  input  logic [WORD-1:0]            PC,
  input  logic                       pipeline_valid,
  input  logic                       memory_ready,
  input  logic [WORD*LINE_WORDS-1:0] data_from_mem,
  output logic [WORD-1:0]            load_addr,
  output logic                       memory_valid,
  output logic                       pipeline_ready,
  output logic [WORD-1:0]            inst
);

  localparam int LINE_W      = WORD * LINE_WORDS;
  localparam int OFFSET_BITS = $clog2(LINE_WORDS * 4);
  localparam int TAG_BITS    = WORD - INDEX_BITS - OFFSET_BITS;
  localparam int WSEL_BITS   = $clog2(LINE_WORDS);
  localparam int LINES       = 1 << INDEX_BITS;

  typedef enum logic [1:0] {IDLE, MISS, REFILL} state_t;

  state_t                 state;
  logic [WORD-1:0]        req_pc_p1;
  logic                   req_vld_p1;
  logic                   discard;
  logic [LINES-1:0]       valid_q;
  logic [TAG_BITS-1:0]    tag_mem [LINES];
  logic [LINE_W-1:0]      data_mem [LINES];
  logic [TAG_BITS-1:0]    rd_tag_p1;
  logic [LINE_W-1:0]      rd_line_p1;
  logic [LINE_W-1:0]      line_buf;

  logic [INDEX_BITS-1:0]  pc_idx;
  logic [INDEX_BITS-1:0]  req_idx;
  logic [INDEX_BITS-1:0]  rd_idx;
  logic [TAG_BITS-1:0]    req_tag;
  logic [WSEL_BITS-1:0]   req_wsel;
  logic                   hit;
  logic                   accept;
  logic                   refill_we;
  logic                   unused_pc_bits;

  function automatic logic [WORD-1:0] sel_word(input logic [LINE_W-1:0] line,
                                               input logic [WSEL_BITS-1:0] w);
    return line[w*WORD +: WORD];
  endfunction

  assign pc_idx         = PC[OFFSET_BITS +: INDEX_BITS];
  assign req_idx        = req_pc_p1[OFFSET_BITS +: INDEX_BITS];
  assign req_tag        = req_pc_p1[WORD-1 -: TAG_BITS];
  assign req_wsel       = req_pc_p1[OFFSET_BITS-1:2];
  assign unused_pc_bits = ^{PC[1:0], req_pc_p1[1:0]};

  assign hit       = req_vld_p1 && valid_q[req_idx] && (rd_tag_p1 == req_tag);
  assign accept    = pipeline_ready && !stall && !flush;
  assign refill_we = (state == MISS) && memory_ready;
  // A held request re-reads its own line so the registered array outputs stay coherent.
  assign rd_idx    = accept ? pc_idx : req_idx;

  // IF1: hit/miss decision and instruction return
  always_comb begin
    pipeline_ready = 1'b1;
    inst           = '0;
    case (state)
      IDLE: begin
        if (req_vld_p1) begin
          if (hit) inst = sel_word(rd_line_p1, req_wsel);
          else     pipeline_ready = 1'b0;
        end
      end
      MISS:    pipeline_ready = 1'b0;
      REFILL:  if (!discard) inst = sel_word(line_buf, req_wsel);
      default: pipeline_ready = 1'b1;
    endcase
  end

  assign memory_valid = (state == MISS);
  assign load_addr    = (state == MISS) ? {req_pc_p1[WORD-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}}
                                        : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      req_vld_p1 <= 1'b0;
      discard    <= 1'b0;
      valid_q    <= '0;
    end else begin
      if (flush)       req_vld_p1 <= 1'b0;
      else if (accept) req_vld_p1 <= pipeline_valid;

      case (state)
        IDLE: if (req_vld_p1 && !hit && !flush) state <= MISS;
        MISS: begin
          // The memory request cannot be withdrawn, so a flush only marks the result dead.
          if (flush) discard <= 1'b1;
          if (memory_ready) begin
            valid_q[req_idx] <= 1'b1;
            state            <= REFILL;
          end
        end
        REFILL: begin
          if (flush || !stall) begin
            state   <= IDLE;
            discard <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // IF0 -> IF1: request capture, synchronous array read, refill write
  always_ff @(posedge clk) begin
    if (accept) req_pc_p1 <= PC;
    rd_tag_p1  <= tag_mem[rd_idx];
    rd_line_p1 <= data_mem[rd_idx];
    if (refill_we) begin
      tag_mem[req_idx]  <= req_tag;
      data_mem[req_idx] <= data_from_mem;
      line_buf          <= data_from_mem;
    end
  end

endmodule

// File: tb/tb_icache_dm.sv
// Scoreboard bench for icache_dm: a delayed memory responder, an IF1 consumer that pops
// expected instructions, and directed checks on miss/refill timing, flush, stall and reset.
module tb_icache_dm;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         stall = 1'b0;
  logic         flush = 1'b0;
  logic [31:0]  PC = '0;
  logic         pipeline_valid = 1'b0;
  logic         memory_ready = 1'b0;
  logic [127:0] data_from_mem = '0;
  logic [31:0]  load_addr;
  logic         memory_valid;
  logic         pipeline_ready;
  logic [31:0]  inst;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          mem_cnt = 0;
  int          lat;
  logic [31:0] exp_q[$];
  logic [31:0] sb_exp;

  icache_dm #(.WORD(32), .LINE_WORDS(4), .INDEX_BITS(6)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .PC(PC),
    .pipeline_valid(pipeline_valid), .memory_ready(memory_ready),
    .data_from_mem(data_from_mem), .load_addr(load_addr),
    .memory_valid(memory_valid), .pipeline_ready(pipeline_ready), .inst(inst)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Backing-store contents; the 0x1C000000 line holds D0..D3.
  function automatic logic [31:0] mword(input logic [31:0] a);
    if (a[31:4] == 28'h1C00000) return 32'h000000D0 + {30'b0, a[3:2]};
    return {a[31:2], 2'b11} ^ 32'h5A5A0000;
  endfunction

  function automatic logic [127:0] mline(input logic [31:0] a);
    logic [127:0] l;
    logic [31:0]  base;
    base = {a[31:4], 4'b0};
    for (int k = 0; k < 4; k++) l[32*k +: 32] = mword(base + 32'(4*k));
    return l;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] a);
    logic done;
    done = 1'b0;
    PC = a;
    pipeline_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (pipeline_ready && !stall && !flush) done = 1'b1;
      step();
    end
    pipeline_valid = 1'b0;
    if (!done) check_eq("fetch_timeout", 32'(done), 32'd1);
  endtask

  task automatic wait_ready(output int n);
    logic done;
    done = 1'b0;
    n = 0;
    while (!done && n <= 40) begin
      @(negedge clk);
      if (pipeline_ready) done = 1'b1;
      else n++;
    end
    if (!done) check_eq("ready_timeout", 32'(done), 32'd1);
  endtask

  // Memory side: answers a refill request 3 cycles after it appears.
  initial forever begin
    step();
    if (!rst) begin
      memory_ready = 1'b0;
      mem_cnt = 0;
    end else if (memory_ready) begin
      memory_ready = 1'b0;
      mem_cnt = 0;
    end else if (memory_valid) begin
      mem_cnt++;
      if (mem_cnt == 3) begin
        memory_ready  = 1'b1;
        data_from_mem = mline(load_addr);
      end
    end
  end

  // IF1 consumer: a slot retires when pipeline_ready && !stall.
  initial forever begin
    @(negedge clk);
    if (!rst) exp_q.delete();
    else begin
      if (pipeline_ready && !stall) begin
        if (exp_q.size() > 0) begin
          sb_exp = exp_q.pop_front();
          check_eq("sb_inst", inst, sb_exp);
        end else check_eq("sb_bubble", inst, 32'h0);
      end else if (flush && exp_q.size() > 0) exp_q[0] = 32'h0;
      if (pipeline_ready && !stall && !flush && pipeline_valid) exp_q.push_back(mword(PC));
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step(); step();
    @(negedge clk);
    check_eq("rst_inst", inst, 32'h0);
    check_eq("rst_ready", 32'(pipeline_ready), 32'd1);
    check_eq("rst_memv", 32'(memory_valid), 32'd0);
    check_eq("rst_load_addr", load_addr, 32'h0);
    step();
    rst = 1'b1;
    step();

    // cold miss
    fetch(32'h1C000008);
    @(negedge clk);
    check_eq("cold_ready", 32'(pipeline_ready), 32'd0);
    check_eq("cold_inst", inst, 32'h0);
    step();
    @(negedge clk);
    check_eq("cold_memv", 32'(memory_valid), 32'd1);
    check_eq("cold_load_addr", load_addr, 32'h1C000000);
    wait_ready(lat);
    check_eq("cold_latency", 32'(lat), 32'd2);
    check_eq("cold_inst_d2", inst, 32'h000000D2);
    check_eq("cold_memv_drop", 32'(memory_valid), 32'd0);
    step();

    // single hit, then back-to-back hits
    fetch(32'h1C00000C);
    @(negedge clk);
    check_eq("hit_inst", inst, 32'h000000D3);
    check_eq("hit_ready", 32'(pipeline_ready), 32'd1);
    check_eq("hit_memv", 32'(memory_valid), 32'd0);
    step();
    for (int i = 0; i < 4; i++) begin
      PC = 32'h1C000000 + 32'(4*i);
      pipeline_valid = 1'b1;
      @(negedge clk);
      if (i > 0) begin
        check_eq("b2b_inst", inst, 32'h000000D0 + 32'(i-1));
        check_eq("b2b_ready", 32'(pipeline_ready), 32'd1);
      end
      step();
    end
    pipeline_valid = 1'b0;
    @(negedge clk);
    check_eq("b2b_last", inst, 32'h000000D3);
    step();

    // conflict miss, then the evicted line misses again
    fetch(32'h1C000408);
    @(negedge clk);
    check_eq("conf_ready", 32'(pipeline_ready), 32'd0);
    step();
    @(negedge clk);
    check_eq("conf_load_addr", load_addr, 32'h1C000400);
    wait_ready(lat);
    check_eq("conf_inst", inst, mword(32'h1C000408));
    step();
    fetch(32'h1C000008);
    @(negedge clk);
    check_eq("remiss_ready", 32'(pipeline_ready), 32'd0);
    step();
    @(negedge clk);
    check_eq("remiss_load_addr", load_addr, 32'h1C000000);
    wait_ready(lat);
    check_eq("remiss_inst", inst, 32'h000000D2);
    step();

    // flush while the refill is outstanding
    fetch(32'h20000010);
    @(negedge clk);
    check_eq("fmiss_ready", 32'(pipeline_ready), 32'd0);
    step();
    flush = 1'b1;
    @(negedge clk);
    step();
    flush = 1'b0;
    @(negedge clk);
    check_eq("fmiss_memv_held", 32'(memory_valid), 32'd1);
    wait_ready(lat);
    check_eq("fmiss_refill_inst", inst, 32'h0);
    step();
    fetch(32'h20000010);
    @(negedge clk);
    check_eq("refetch_ready", 32'(pipeline_ready), 32'd1);
    check_eq("refetch_inst", inst, mword(32'h20000010));
    step();

    // stall holds a hit and blocks the next PC
    fetch(32'h1C000004);
    stall = 1'b1;
    PC = 32'h1C00000C;
    pipeline_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("stall_inst", inst, 32'h000000D1);
      check_eq("stall_ready", 32'(pipeline_ready), 32'd1);
      step();
    end
    stall = 1'b0;
    @(negedge clk);
    check_eq("unstall_inst", inst, 32'h000000D1);
    step();
    pipeline_valid = 1'b0;
    @(negedge clk);
    check_eq("after_stall_inst", inst, 32'h000000D3);
    step();

    // flush together with stall kills the request
    fetch(32'h1C000008);
    stall = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    check_eq("fs_cur_inst", inst, 32'h000000D2);
    step();
    stall = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    check_eq("fs_killed_inst", inst, 32'h0);
    check_eq("fs_ready", 32'(pipeline_ready), 32'd1);
    step();

    // reset in the middle of a refill
    fetch(32'h30000000);
    step();
    @(negedge clk);
    check_eq("prerst_memv", 32'(memory_valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    check_eq("mrst_memv", 32'(memory_valid), 32'd0);
    check_eq("mrst_ready", 32'(pipeline_ready), 32'd1);
    check_eq("mrst_inst", inst, 32'h0);
    check_eq("mrst_load_addr", load_addr, 32'h0);
    step(); step();
    rst = 1'b1;
    step();
    fetch(32'h1C000008);
    @(negedge clk);
    check_eq("postrst_miss", 32'(pipeline_ready), 32'd0);
    step();
    @(negedge clk);
    check_eq("postrst_load_addr", load_addr, 32'h1C000000);
    wait_ready(lat);
    check_eq("postrst_inst", inst, 32'h000000D2);
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
